// File: rtl/norm_arbiter.sv
// Round-robin per-vector arbiter feeding a shared sum-of-squares / floor-sqrt datapath.
// Latency: result pulses 2 cycles after the LEN-th accepted sample; min vector period LEN+3.
// Backpressure: only the owner sees ready (until LEN accepts); the other channel waits for IDLE.
module norm_arbiter #(
    parameter int LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       res_valid,
    output logic       res_id,
    output logic [9:0] res_norm
);

    localparam logic [4:0] LEN_C = 5'(LEN);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [4:0]  count_q, count_d;
    logic        drain_q, drain_d;
    logic [7:0]  sample_q, sample_d;
    logic        sample_vld_q, sample_vld_d;
    logic [19:0] acc_q, acc_d;
    logic        res_valid_q, res_valid_d;
    logic        res_id_q, res_id_d;
    logic [9:0]  res_norm_q, res_norm_d;

    logic        own_vld;
    logic [7:0]  own_data;
    logic        own_rdy;
    logic [15:0] sq;
    logic [9:0]  root;

    // Bit-serial restoring floor square root: tries each root bit from MSB down.
    function automatic logic [9:0] floor_sqrt(input logic [19:0] v);
        logic [9:0]  r;
        logic [9:0]  t;
        logic [19:0] t2;
        r = '0;
        for (int i = 9; i >= 0; i--) begin
            t  = r | (10'd1 << i);
            t2 = {10'd0, t} * {10'd0, t};
            if (t2 <= v) begin
                r = t;
            end
        end
        return r;
    endfunction

    assign own_vld    = owner_q ? req1_valid : req0_valid;
    assign own_data   = owner_q ? req1_data : req0_data;
    assign own_rdy    = (state_q == STREAM) && (count_q < LEN_C);
    assign req0_ready = own_rdy && !owner_q;
    assign req1_ready = own_rdy && owner_q;
    assign sq         = {8'd0, sample_q} * {8'd0, sample_q};
    assign root       = floor_sqrt(acc_q);

    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_norm   = res_norm_q;

    // Next-state: arbitration, sample capture, square-accumulate and result launch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        count_d      = count_q;
        drain_d      = drain_q;
        sample_d     = sample_q;
        sample_vld_d = 1'b0;
        acc_d        = acc_q;
        res_valid_d  = 1'b0;
        res_id_d     = res_id_q;
        res_norm_d   = res_norm_q;

        if (sample_vld_q) begin
            acc_d = acc_q + {4'd0, sq};
        end

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the channel not served last wins.
                    owner_d = (req0_valid && req1_valid) ? ~last_q : !req0_valid;
                    acc_d   = '0;
                    count_d = '0;
                    drain_d = 1'b0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (own_vld && own_rdy) begin
                    sample_d     = own_data;
                    sample_vld_d = 1'b1;
                    count_d      = count_q + 5'd1;
                    if (count_q == LEN_C - 5'd1) begin
                        drain_d = 1'b0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // First cycle lets the last square land in acc; second publishes.
                if (drain_q) begin
                    res_valid_d = 1'b1;
                    res_id_d    = owner_q;
                    res_norm_d  = root;
                    last_d      = owner_q;
                    state_d     = IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous reset; a partial vector is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            count_q      <= '0;
            drain_q      <= 1'b0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            acc_q        <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_norm_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            count_q      <= count_d;
            drain_q      <= drain_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            acc_q        <= acc_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_norm_q   <= res_norm_d;
        end
    end

endmodule

// File: tb/tb_norm_arbiter.sv
// Scoreboard bench for norm_arbiter: producers with random bubbles, vector-level reference model.
// Latency: expected results carry the exact cycle they must appear (2 edges after the last accept).
// Backpressure: producers hold valid/data until accepted; the monitor checks grants and ready ownership.
module tb_norm_arbiter;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'd0;
    logic       req1_ready;
    logic       res_valid;
    logic       res_id;
    logic [9:0] res_norm;

    norm_arbiter #(.LEN(LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_norm   (res_norm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int norm;
        int due;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   bub_pct = 0;
    int   nacc1 = 0;
    int   q0[$];
    int   q1[$];
    exp_t expq[$];
    int   got_id[$];
    int   got_norm[$];

    // reference model state (vector level)
    int   owner_m = 0;
    int   last_m = 1;
    int   cnt_m[2];
    int   sum_m[2];
    bit   pr0, pr1, pv0, pv1, exp_grant;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int got, input int exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic int isqrt_m(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic model_accept(input int c, input int d);
        if (c != owner_m) fail("accept_owner", c, owner_m);
        sum_m[c] += d * d;
        cnt_m[c]++;
        if (cnt_m[c] > LEN) fail("ready_after_len", cnt_m[c], LEN);
        if (cnt_m[c] == LEN) begin
            exp_t e;
            e.id   = c;
            e.norm = isqrt_m(sum_m[c]);
            e.due  = cyc + 3;
            expq.push_back(e);
        end
    endtask

    // Monitor: pops/compares results, checks grants, feeds accepts to the model.
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            cnt_m = '{0, 0};
            sum_m = '{0, 0};
            last_m = 1;
            pr0 = 0;
            pr1 = 0;
            exp_grant = 0;
            pv0 = req0_valid;
            pv1 = req1_valid;
        end else begin
            if (exp_grant) begin
                chk("back_to_back_grant", int'(req0_ready | req1_ready), 1);
                exp_grant = 0;
            end
            if (res_valid) begin
                if (expq.size() == 0) begin
                    fail("unexpected_result", int'(res_norm), -1);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("res_id", int'(res_id), e.id);
                    chk("res_norm", int'(res_norm), e.norm);
                    chk("res_cycle", cyc, e.due);
                    last_m = e.id;
                end
                got_id.push_back(int'(res_id));
                got_norm.push_back(int'(res_norm));
                exp_grant = req0_valid | req1_valid;
            end else if (expq.size() > 0 && cyc > expq[0].due) begin
                fail("result_timeout", cyc, expq[0].due);
                void'(expq.pop_front());
            end
            if (req0_ready && req1_ready) fail("both_ready", 1, 0);
            if (!pr0 && !pr1 && (req0_ready || req1_ready)) begin
                if (!pv0 && !pv1) begin
                    fail("grant_without_valid", int'(req1_ready), -1);
                end else begin
                    chk("grant_ch", int'(req1_ready), (pv0 && pv1) ? 1 - last_m : (pv0 ? 0 : 1));
                end
                owner_m = req1_ready ? 1 : 0;
                cnt_m[owner_m] = 0;
                sum_m[owner_m] = 0;
            end
            if (req0_valid && req0_ready) model_accept(0, int'(req0_data));
            if (req1_valid && req1_ready) model_accept(1, int'(req1_data));
            pr0 = req0_ready;
            pr1 = req1_ready;
            pv0 = req0_valid;
            pv1 = req1_valid;
        end
    end

    // Producer drive: hold while stalled, otherwise present next sample (maybe a bubble).
    task automatic drive_inputs(input bit a0, input bit a1);
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        if (q0.size() == 0) begin
            req0_valid = 1'b0;
        end else if (!(req0_valid && !a0)) begin
            req0_valid = ($urandom_range(0, 99) >= bub_pct);
            req0_data  = 8'(q0[0]);
        end
        if (q1.size() == 0) begin
            req1_valid = 1'b0;
        end else if (!(req1_valid && !a1)) begin
            req1_valid = ($urandom_range(0, 99) >= bub_pct);
            req1_data  = 8'(q1[0]);
        end
    endtask

    task automatic tick();
        bit a0, a1;
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (a1) nacc1++;
        drive_inputs(a0, a1);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || expq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) fail("drain_timeout", n, budget);
        tick();
    endtask

    // Asserts reset between edges and checks outputs clear without a clock edge.
    task automatic reset_assert();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_norm", int'(res_norm), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        q0.delete();
        q1.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        got_id.delete();
        got_norm.delete();
    endtask

    task automatic reset_release();
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic check_results(input string name, input int ids[4], input int norms[4], input int n);
        if (got_id.size() < n) begin
            fail({name, "_count"}, got_id.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                chk({name, "_id"}, got_id[i], ids[i]);
                chk({name, "_norm"}, got_norm[i], norms[i]);
            end
        end
    endtask

    initial begin
        int budget;
        // reset state, then idle with no valids
        #2;
        chk("init_res_valid", int'(res_valid), 0);
        chk("init_res_norm", int'(res_norm), 0);
        chk("init_ready", int'(req0_ready | req1_ready), 0);
        reset_release();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", int'(req0_ready | req1_ready), 0);
            chk("idle_res_valid", int'(res_valid), 0);
        end

        // single vector on ch0
        bub_pct = 0;
        got_id.delete();
        got_norm.delete();
        q0 = '{3, 4, 0, 0};
        drive_inputs(0, 0);
        run_until_idle(100);
        check_results("single", '{0, 0, 0, 0}, '{5, 0, 0, 0}, 1);

        // tie from reset release, round-robin, zero vector
        reset_assert();
        q0 = '{1, 2, 2, 0, 0, 0, 0, 0};
        q1 = '{255, 255, 255, 255, 1, 1, 1, 1};
        drive_inputs(0, 0);
        reset_release();
        run_until_idle(200);
        check_results("tie_rr", '{0, 1, 0, 1}, '{3, 510, 0, 2}, 4);

        // floor rounding
        got_id.delete();
        got_norm.delete();
        q0 = '{10, 21, 36, 0};
        drive_inputs(0, 0);
        run_until_idle(100);
        check_results("floor", '{0, 0, 0, 0}, '{42, 0, 0, 0}, 1);

        // reset after ch1's 2nd accept: no result, no residue
        q1 = '{7, 7, 7, 7};
        drive_inputs(0, 0);
        nacc1 = 0;
        budget = 0;
        while (nacc1 < 2 && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) fail("ch1_accept_timeout", nacc1, 2);
        reset_assert();
        q0 = '{3, 4, 0, 0};
        q1 = '{6, 8, 0, 0};
        drive_inputs(0, 0);
        reset_release();
        run_until_idle(200);
        check_results("post_reset", '{0, 1, 0, 0}, '{5, 10, 0, 0}, 2);

        // random vectors with bubbles on both channels
        bub_pct = 30;
        for (int v = 0; v < 12; v++) begin
            for (int k = 0; k < LEN; k++) begin
                q0.push_back((v % 4 == 3) ? 255 : int'($urandom_range(0, 255)));
                q1.push_back(int'($urandom_range(0, 255)));
            end
        end
        drive_inputs(0, 0);
        run_until_idle(3000);

        repeat (5) tick();
        if (expq.size() != 0) fail("leftover_expected", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
